// File: rtl/fpu_op_scheduler_if.sv
// Request/response bundle between two FP requesters plus one consumer and fpu_op_scheduler.
// master = requester/consumer side, slave = scheduler side.
interface fpu_op_scheduler_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [5:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id;
    logic        rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );
endinterface

// File: rtl/fpu_op_scheduler.sv
// Round-robin scheduler sharing one FP ALU between two requesters, one operation in flight.
// Defining FPU_SCHED_PERF_EN adds saturating perf_ops / perf_stall counter outputs.
module fpu_op_scheduler #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpu_op_scheduler_if.slave    bus,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [2:0]           alu_oper,
    input  logic [31:0]          alu_add_sub,
    input  logic [31:0]          alu_mul,
    input  logic [31:0]          alu_div,
    input  logic [2:0]           alu_cmp,
    output logic                 busy
`ifdef FPU_SCHED_PERF_EN
    ,
    output logic [15:0]          perf_ops,
    output logic [15:0]          perf_stall
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state_r;
    state_t      state_nx_s;
    logic        rr_ptr_r;
    logic [3:0]  cnt_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [2:0]  op_r;
    logic        id_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_data_r;
    logic        rsp_id_r;
    logic        rsp_err_r;
    logic        busy_r;

    logic [1:0]  grant_s;
    logic        accept_s;
    logic        grant_id_s;
    logic        rsp_done_s;
    logic [31:0] sel_a_s;
    logic [31:0] sel_b_s;
    logic [2:0]  sel_op_s;
    logic [31:0] result_s;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= 3'd4);
    endfunction

    // Round-robin grant, offered only from IDLE and suppressed while reset is asserted
    always_comb begin
        grant_s = 2'b00;
        if (rst_n && (state_r == IDLE)) begin
            case (bus.req_valid)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = rr_ptr_r ? 2'b10 : 2'b01;
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
    end

    assign accept_s   = |grant_s;
    assign grant_id_s = grant_s[1];
    assign sel_a_s    = grant_id_s ? bus.req_a[63:32] : bus.req_a[31:0];
    assign sel_b_s    = grant_id_s ? bus.req_b[63:32] : bus.req_b[31:0];
    assign sel_op_s   = grant_id_s ? bus.req_op[5:3]  : bus.req_op[2:0];
    assign rsp_done_s = rsp_valid_r & bus.rsp_ready;

    // Next-state logic; illegal opcodes skip the ALU wait entirely
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = op_is_legal(sel_op_s) ? EXEC : RESP;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == 4'd0) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = EXEC;
                end
            end
            RESP: begin
                if (rsp_done_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Select the ALU result belonging to the latched opcode
    always_comb begin
        result_s = 32'd0;
        case (op_r)
            3'd0, 3'd1: result_s = alu_add_sub;
            3'd2:       result_s = alu_mul;
            3'd3:       result_s = alu_div;
            3'd4:       result_s = {29'd0, alu_cmp};
            default:    result_s = 32'd0;
        endcase
    end

    // State register and registered busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != IDLE);
        end
    end

    // Operand latch, settle countdown and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r    <= 1'b0;
            cnt_r       <= 4'd0;
            a_r         <= 32'd0;
            b_r         <= 32'd0;
            op_r        <= 3'd0;
            id_r        <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 32'd0;
            rsp_id_r    <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else if (accept_s) begin
            a_r      <= sel_a_s;
            b_r      <= sel_b_s;
            op_r     <= sel_op_s;
            id_r     <= grant_id_s;
            rr_ptr_r <= ~grant_id_s;
            if (op_is_legal(sel_op_s)) begin
                cnt_r <= CNT_LOAD;
            end else begin
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= 32'd0;
                rsp_id_r    <= grant_id_s;
                rsp_err_r   <= 1'b1;
            end
        end else if (state_r == EXEC) begin
            if (cnt_r == 4'd0) begin
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= result_s;
                rsp_id_r    <= id_r;
                rsp_err_r   <= 1'b0;
            end else begin
                cnt_r <= cnt_r - 4'd1;
            end
        end else if (rsp_done_s) begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_err   = rsp_err_r;
    assign alu_a         = a_r;
    assign alu_b         = b_r;
    assign alu_oper      = op_r;
    assign busy          = busy_r;

`ifdef FPU_SCHED_PERF_EN
    logic [15:0] perf_ops_r;
    logic [15:0] perf_stall_r;

    // Saturating counters of completed handshakes and back-pressured response cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_r   <= 16'd0;
            perf_stall_r <= 16'd0;
        end else begin
            if (rsp_done_s && (perf_ops_r != 16'hFFFF)) begin
                perf_ops_r <= perf_ops_r + 16'd1;
            end
            if (rsp_valid_r && !bus.rsp_ready && (perf_stall_r != 16'hFFFF)) begin
                perf_stall_r <= perf_stall_r + 16'd1;
            end
        end
    end

    assign perf_ops   = perf_ops_r;
    assign perf_stall = perf_stall_r;
`endif

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Self-checking bench for fpu_op_scheduler: directed cases plus randomized transactions
// checked against a transaction-level reference (round-robin pointer, latency, result table).
module tb_fpu_op_scheduler;

    localparam int unsigned SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_oper;
    logic [31:0] alu_add_sub;
    logic [31:0] alu_mul;
    logic [31:0] alu_div;
    logic [2:0]  alu_cmp;
    logic        busy;
`ifdef FPU_SCHED_PERF_EN
    logic [15:0] perf_ops;
    logic [15:0] perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int rr_m     = 0;
    int exp_ops  = 0;
    int exp_stall = 0;

    fpu_op_scheduler_if bus_if ();

    fpu_op_scheduler #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_oper    (alu_oper),
        .alu_add_sub (alu_add_sub),
        .alu_mul     (alu_mul),
        .alu_div     (alu_div),
        .alu_cmp     (alu_cmp),
        .busy        (busy)
`ifdef FPU_SCHED_PERF_EN
        ,
        .perf_ops    (perf_ops),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // ALU stub: deterministic functions of the operands; add of 6.0+6.0 yields 12.0 (0x41400000)
    function automatic logic [31:0] stub_addsub(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        return (op == 3'd1) ? (a - b + 32'h0000_1234) : (a + b - 32'h4040_0000);
    endfunction
    function automatic logic [31:0] stub_mul(input logic [31:0] a, input logic [31:0] b);
        return a ^ {b[15:0], b[31:16]};
    endfunction
    function automatic logic [31:0] stub_div(input logic [31:0] a, input logic [31:0] b);
        return ~a + b;
    endfunction
    function automatic logic [2:0] stub_cmp(input logic [31:0] a, input logic [31:0] b);
        return {a < b, a > b, a == b};
    endfunction

    assign alu_add_sub = stub_addsub(alu_a, alu_b, alu_oper);
    assign alu_mul     = stub_mul(alu_a, alu_b);
    assign alu_div     = stub_div(alu_a, alu_b);
    assign alu_cmp     = stub_cmp(alu_a, alu_b);

    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return stub_addsub(a, b, op);
            3'd2:       return stub_mul(a, b);
            3'd3:       return stub_div(a, b);
            3'd4:       return {29'd0, stub_cmp(a, b)};
            default:    return 32'd0;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_perf();
`ifdef FPU_SCHED_PERF_EN
        check_eq("perf_ops", 64'(perf_ops), 64'(exp_ops));
        check_eq("perf_stall", 64'(perf_stall), 64'(exp_stall));
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_rsp_valid"}, 64'(bus_if.rsp_valid), 64'd0);
        check_eq({tag, "_rsp_data"},  64'(bus_if.rsp_data),  64'd0);
        check_eq({tag, "_rsp_id"},    64'(bus_if.rsp_id),    64'd0);
        check_eq({tag, "_rsp_err"},   64'(bus_if.rsp_err),   64'd0);
        check_eq({tag, "_alu_a"},     64'(alu_a),            64'd0);
        check_eq({tag, "_alu_b"},     64'(alu_b),            64'd0);
        check_eq({tag, "_alu_oper"},  64'(alu_oper),         64'd0);
        check_eq({tag, "_busy"},      64'(busy),             64'd0);
        check_eq({tag, "_req_ready"}, 64'(bus_if.req_ready), 64'd0);
        check_perf();
    endtask

    // One full transaction: offer, accept, wait for response, optional back-pressure, handshake
    task automatic run_txn(input logic [1:0] vld, input logic [2:0] op0, input logic [2:0] op1,
                           input logic [31:0] a0, input logic [31:0] b0,
                           input logic [31:0] a1, input logic [31:0] b1, input int stall);
        int          gid;
        int          lat;
        bit          seen;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [2:0]  eop;
        logic [31:0] edata;
        logic        eerr;
        @(negedge clk);
        bus_if.req_valid = vld;
        bus_if.req_a     = {a1, a0};
        bus_if.req_b     = {b1, b0};
        bus_if.req_op    = {op1, op0};
        #1;
        gid = (vld == 2'b11) ? rr_m : ((vld == 2'b10) ? 1 : 0);
        check_eq("req_ready_grant", 64'(bus_if.req_ready), (gid == 1) ? 64'h2 : 64'h1);
        ea    = (gid == 1) ? a1 : a0;
        eb    = (gid == 1) ? b1 : b0;
        eop   = (gid == 1) ? op1 : op0;
        edata = ref_result(ea, eb, eop);
        eerr  = (eop > 3'd4);
        rr_m  = 1 - gid;
        @(posedge clk);
        lat  = 1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (bus_if.rsp_valid) begin
                seen = 1'b1;
            end else begin
                check_eq("req_ready_exec", 64'(bus_if.req_ready), 64'd0);
                bus_if.req_valid = 2'($urandom);
                bus_if.req_a     = {$urandom, $urandom};
                bus_if.req_b     = {$urandom, $urandom};
                bus_if.req_op    = 6'($urandom);
                @(posedge clk);
                lat++;
            end
        end
        bus_if.req_valid = 2'b00;
        check_eq("rsp_arrived", 64'(seen), 64'd1);
        check_eq("latency", 64'(lat), eerr ? 64'd1 : 64'(SETTLE + 1));
        check_eq("rsp_data", 64'(bus_if.rsp_data), 64'(edata));
        check_eq("rsp_id", 64'(bus_if.rsp_id), 64'(gid));
        check_eq("rsp_err", 64'(bus_if.rsp_err), 64'(eerr));
        check_eq("busy_resp", 64'(busy), 64'd1);
        check_eq("alu_a_held", 64'(alu_a), 64'(ea));
        check_eq("alu_b_held", 64'(alu_b), 64'(eb));
        check_eq("alu_oper_held", 64'(alu_oper), 64'(eop));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            exp_stall++;
            @(negedge clk);
            #1;
            check_eq("stall_rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
            check_eq("stall_rsp_data", 64'(bus_if.rsp_data), 64'(edata));
            check_eq("stall_rsp_id", 64'(bus_if.rsp_id), 64'(gid));
            check_eq("stall_req_ready", 64'(bus_if.req_ready), 64'd0);
            bus_if.req_valid = 2'($urandom);
        end
        bus_if.req_valid = 2'b00;
        bus_if.rsp_ready = 1'b1;
        @(posedge clk);
        exp_ops++;
        #1;
        bus_if.rsp_ready = 1'b0;
        check_eq("post_hs_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
        check_eq("post_hs_busy", 64'(busy), 64'd0);
        check_perf();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n            = 1'b0;
        bus_if.req_valid = 2'b00;
        bus_if.req_a     = 64'd0;
        bus_if.req_b     = 64'd0;
        bus_if.req_op    = 6'd0;
        bus_if.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Both valid after reset: r0 (mul) first, then r1 (div)
        run_txn(2'b11, 3'd2, 3'd3, 32'h3F80_0000, 32'h4000_0000, 32'h4110_0000, 32'h4040_0000, 0);
        run_txn(2'b11, 3'd2, 3'd3, 32'h3F80_0000, 32'h4000_0000, 32'h4110_0000, 32'h4040_0000, 0);
        // 6.0 + 6.0 on r0
        run_txn(2'b01, 3'd0, 3'd0, 32'h40C0_0000, 32'h40C0_0000, 32'h0, 32'h0, 0);
        check_eq("add_value", 64'(bus_if.rsp_data), 64'h4140_0000);
        // Compare of equal operands
        run_txn(2'b10, 3'd0, 3'd4, 32'h0, 32'h0, 32'h4248_0000, 32'h4248_0000, 0);
        check_eq("cmp_value", 64'(bus_if.rsp_data), 64'h1);
        // Illegal opcode on r1
        run_txn(2'b10, 3'd0, 3'd6, 32'h0, 32'h0, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        // Five cycles of back-pressure
        run_txn(2'b01, 3'd1, 3'd0, 32'h4100_0000, 32'h3F80_0000, 32'h0, 32'h0, 5);

        // Reset asserted mid-EXEC discards the operation
        @(negedge clk);
        bus_if.req_valid = 2'b01;
        bus_if.req_op    = 6'd2;
        bus_if.req_a     = {$urandom, $urandom};
        bus_if.req_b     = {$urandom, $urandom};
        #1;
        check_eq("rst_case_grant", 64'(bus_if.req_ready), 64'h1);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        rr_m      = 0;
        exp_ops   = 0;
        exp_stall = 0;
        check_idle_outputs("async_rst");
        @(negedge clk);
        bus_if.req_valid = 2'b00;
        rst_n            = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_eq("no_rsp_after_rst", 64'(bus_if.rsp_valid), 64'd0);
        end
        run_txn(2'b01, 3'd0, 3'd0, 32'h40C0_0000, 32'h40C0_0000, 32'h0, 32'h0, 1);

        // Randomized traffic
        for (int t = 0; t < 120; t++) begin
            run_txn(2'($urandom_range(1, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    $urandom, $urandom, $urandom, $urandom, int'($urandom_range(0, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_op_scheduler.md
FPU_OP_SCHEDULER -- requirements
Module: fpu_op_scheduler

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles ALU inputs are held stable before result capture; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester grant/accept; at most one bit high.
REQ-006 req_a  input  64  packed operand A {r1[31:0], r0[31:0]}, IEEE-754 single.
REQ-007 req_b  input  64  packed operand B, same packing.
REQ-008 req_op  input  6  packed opcode {r1[2:0], r0[2:0]}.
REQ-009 alu_a  output  32  operand A driven to the shared FP ALU.
REQ-010 alu_b  output  32  operand B driven to the shared FP ALU.
REQ-011 alu_oper  output  3  opcode driven to the shared FP ALU.
REQ-012 alu_add_sub  input  32  ALU add/subtract result.
REQ-013 alu_mul  input  32  ALU multiply result.
REQ-014 alu_div  input  32  ALU divide result.
REQ-015 alu_cmp  input  3  ALU compare flags {LS, GT, EQ}.
REQ-016 rsp_valid  output  1  response valid.
REQ-017 rsp_ready  input  1  response accepted by consumer.
REQ-018 rsp_data  output  32  response result.
REQ-019 rsp_id  output  1  requester index owning the response.
REQ-020 rsp_err  output  1  response carries illegal-opcode error.
REQ-021 busy  output  1  high in any state other than IDLE.

Function
REQ-022 Opcodes: 000 add, 001 sub, 010 mul, 011 div, 100 compare; 101-111 illegal.
REQ-023 FSM states IDLE, EXEC, RESP; one operation in flight at a time, no overlap.
REQ-024 req_ready is nonzero only in IDLE: the single granted bit when any req_valid is high, else 00.
REQ-025 Arbitration round-robin: one valid requester -> granted; both valid -> requester rr_ptr granted; after each accept rr_ptr becomes the non-granted index.
REQ-026 Accept edge (req_valid[i] & req_ready[i]) latches a, b, op, id into internal registers; alu_a/alu_b/alu_oper are driven from these registers and stay stable until the next accept.
REQ-027 Legal op: IDLE -> EXEC, settle counter loaded with SETTLE_CYCLES-1, decremented each cycle in EXEC.
REQ-028 In EXEC, at the edge with counter 0: rsp_data captured (000/001 -> alu_add_sub, 010 -> alu_mul, 011 -> alu_div, 100 -> {29'b0, alu_cmp}), rsp_err=0, -> RESP.
REQ-029 Illegal op: IDLE -> RESP directly at the accept edge, rsp_data=0, rsp_err=1, no ALU wait.
REQ-030 Latency, legal op: rsp_valid rises SETTLE_CYCLES+1 edges after the accept edge, counting the accept edge itself.
REQ-031 RESP: rsp_valid=1; rsp_data, rsp_id, rsp_err held constant until the rsp_valid & rsp_ready edge, then -> IDLE with rsp_valid=0.
REQ-032 No request is accepted in the cycle the response handshake completes; earliest next accept is the following edge.
REQ-033 Changes on req_* while busy have no effect on the in-flight operation.

Reset
REQ-034 rst_n low immediately forces: state IDLE, rr_ptr 0, counter 0, rsp_valid 0, rsp_data 0, rsp_id 0, rsp_err 0, alu_a 0, alu_b 0, alu_oper 000, busy 0; req_ready evaluates to 00.
REQ-035 Reset during EXEC or RESP discards the operation; no response is ever produced for it.

Configuration
REQ-036 Macro FPU_SCHED_PERF_EN defined: adds outputs perf_ops (16, count of completed response handshakes) and perf_stall (16, cycles with rsp_valid & !rsp_ready); both saturate at 0xFFFF and reset to 0.
REQ-037 FPU_SCHED_PERF_EN undefined: perf ports and counters are absent; all other behaviour is identical.

Verification
REQ-038 Bench ALU stub returns 0x41400000 on add_sub. r0 add with a=b=0x40C00000 and SETTLE_CYCLES=2 -> rsp_valid 3 edges after accept, rsp_data=0x41400000, rsp_id=0, rsp_err=0.
REQ-039 Both requesters valid with r0 op 010 and r1 op 011 -> r0 served first, then r1; rsp_data matches alu_mul, then alu_div; rsp_id sequence 0,1.
REQ-040 Compare op with stub alu_cmp=3'b001 -> rsp_data=0x00000001.
REQ-041 r1 op 110 -> rsp_valid on the edge after accept, rsp_err=1, rsp_data=0, ALU outputs never wait.
REQ-042 rsp_ready held low 5 cycles during RESP -> rsp_data stable throughout, req_ready=00 throughout; with FPU_SCHED_PERF_EN, perf_stall=5 and perf_ops=1 after the handshake.
REQ-043 rst_n pulsed low in EXEC -> all outputs 0 at once, no response afterwards, next request is served normally.
